// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg
// Shared definitions for the clock/reset sequencer slice.
//   state_e     - sequencer FSM state encoding
//   LOCK_CNT_W  - width of the saturating lock-loss counter
//   cnt_width() - width of a counter that holds 0..limit-1 (at least 1 bit)
package clk_rst_pkg;

  localparam int LOCK_CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_SETTLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  // A counter that must hold 0..limit-1 needs ceil(log2(limit)) bits, and a
  // limit of 1 still needs a single bit so the vector is never zero width.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for a single asynchronous bit into the clk domain.
// Both flops clear asynchronously to 0 while rst_n is low; the output follows
// the input two clk edges later.
//   clk   - destination clock
//   rst_n - asynchronous active-low clear for both flops
//   d     - asynchronous input bit
//   q     - synchronised output bit
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // The first stage may go metastable; the second stage gives it a full
  // cycle to resolve before anything downstream looks at the value.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages clear asynchronously so the output is a known 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clk_rst_seq.sv
// clk_rst_seq
// Power-up sequencer for the PLL clock domain. It synchronises the board reset
// button, waits for the PLL to report lock, requires the lock to stay stable
// for SETTLE_CYCLES cycles, then releases the downstream reset and runs a
// microsecond / millisecond tick generator. Lock losses while running are
// counted (saturating) and send the sequencer back to waiting for lock.
//   sys_clk       - PLL output clock, the only clock
//   sys_rst_n     - asynchronous active-low board reset
//   pll_lock      - PLL lock flag, asynchronous to sys_clk
//   rst_out_n     - registered active-low reset for downstream logic
//   ready         - registered, high while running
//   tick_us       - one-cycle pulse every US_DIV cycles while running
//   tick_ms       - one-cycle pulse every MS_DIV tick_us pulses while running
//   lock_loss_cnt - saturating count of lock losses seen while running
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int US_DIV        = 159,
  parameter int MS_DIV        = 1000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  pll_lock,
  output logic                  rst_out_n,
  output logic                  ready,
  output logic                  tick_us,
  output logic                  tick_ms,
  output logic [LOCK_CNT_W-1:0] lock_loss_cnt
);

  localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);
  localparam int US_W     = cnt_width(US_DIV);
  localparam int MS_W     = cnt_width(MS_DIV);

  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [US_W-1:0]     US_MAX     = US_W'(US_DIV - 1);
  localparam logic [MS_W-1:0]     MS_MAX     = MS_W'(MS_DIV - 1);

  // Parameter sets that would give an empty settle window, a tick every cycle
  // or a zero-length millisecond are refused when the design is elaborated.
  if (SETTLE_CYCLES < 1 || US_DIV < 2 || MS_DIV < 1) begin : g_bad_params
    $error("clk_rst_seq: SETTLE_CYCLES must be >= 1, US_DIV >= 2, MS_DIV >= 1");
  end

  logic rst_int_n;
  logic lock_s;
  logic lock_gated;

  state_e state_q;
  state_e state_d;

  logic armed_q;
  logic armed_d;

  logic [SETTLE_W-1:0]   settle_cnt_q;
  logic [SETTLE_W-1:0]   settle_cnt_d;
  logic [US_W-1:0]       us_cnt_q;
  logic [US_W-1:0]       us_cnt_d;
  logic [MS_W-1:0]       ms_cnt_q;
  logic [MS_W-1:0]       ms_cnt_d;
  logic [LOCK_CNT_W-1:0] loss_cnt_q;
  logic [LOCK_CNT_W-1:0] loss_cnt_d;

  logic rst_out_n_q;
  logic ready_q;
  logic run_d;
  logic tick_us_q;
  logic tick_us_d;
  logic tick_ms_q;
  logic tick_ms_d;

  // The board button becomes the internal reset: it asserts immediately and
  // releases two sys_clk edges after the pin goes high.
  sync_2ff u_rst_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (1'b1),
    .q     (rst_int_n)
  );

  // The lock synchroniser only starts filling once the sequencer has left
  // S_IDLE, so a lock that is already present at power-up is still seen
  // through the full two-flop latency after S_WAIT_LOCK is entered.
  assign lock_gated = pll_lock & armed_q;

  sync_2ff u_lock_sync (
    .clk   (sys_clk),
    .rst_n (rst_int_n),
    .d     (lock_gated),
    .q     (lock_s)
  );

  // Sequencer next state. The settle counter is held at zero outside
  // S_SETTLE so every settle window starts from scratch, and a lock drop on
  // the final settle cycle is checked first so that it wins over S_RUN.
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    settle_cnt_d = '0;
    loss_cnt_d   = loss_cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT_LOCK;
        armed_d = 1'b1;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (settle_cnt_q == SETTLE_MAX) begin
          state_d = S_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          if (loss_cnt_q != {LOCK_CNT_W{1'b1}}) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tick generation. Outputs are registered, so each tick is computed from
  // the counter values the next cycle will hold. The counters are zero in
  // every cycle outside S_RUN, including the first cycle of S_RUN, which puts
  // the first tick_us exactly US_DIV cycles after entry. The ms counter steps
  // on the edge that closes a tick_us cycle.
  always_comb begin
    run_d    = (state_d == S_RUN);
    us_cnt_d = '0;
    ms_cnt_d = '0;
    if (run_d && (state_q == S_RUN)) begin
      if (us_cnt_q == US_MAX) begin
        us_cnt_d = '0;
      end else begin
        us_cnt_d = us_cnt_q + 1'b1;
      end
      ms_cnt_d = ms_cnt_q;
      if (tick_us_q) begin
        if (ms_cnt_q == MS_MAX) begin
          ms_cnt_d = '0;
        end else begin
          ms_cnt_d = ms_cnt_q + 1'b1;
        end
      end
    end
    tick_us_d = run_d && (us_cnt_d == US_MAX);
    tick_ms_d = tick_us_d && (ms_cnt_d == MS_MAX);
  end

  // All sequencer state and every output live here, cleared by the internal
  // reset so that pulling the button drops rst_out_n without waiting for a
  // clock edge.
  always_ff @(posedge sys_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= S_IDLE;
      armed_q      <= 1'b0;
      settle_cnt_q <= '0;
      us_cnt_q     <= '0;
      ms_cnt_q     <= '0;
      loss_cnt_q   <= '0;
      rst_out_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      tick_us_q    <= 1'b0;
      tick_ms_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      settle_cnt_q <= settle_cnt_d;
      us_cnt_q     <= us_cnt_d;
      ms_cnt_q     <= ms_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      rst_out_n_q  <= run_d;
      ready_q      <= run_d;
      tick_us_q    <= tick_us_d;
      tick_ms_q    <= tick_ms_d;
    end
  end

  assign rst_out_n     = rst_out_n_q;
  assign ready         = ready_q;
  assign tick_us       = tick_us_q;
  assign tick_ms       = tick_ms_q;
  assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq
// Self-checking bench for clk_rst_seq with SETTLE_CYCLES=16, US_DIV=4,
// MS_DIV=5. A behavioural model tracks how long the synchronised lock has
// been continuously high and derives run state, ticks and the loss count
// from that streak; a compare process checks it every cycle, and the main
// sequence adds hand-computed literal expectations for the key scenarios.
module tb_clk_rst_seq;

  localparam int SETTLE_CYCLES = 16;
  localparam int US_DIV        = 4;
  localparam int MS_DIV        = 5;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pll_lock  = 1'b1;
  logic       rst_out_n;
  logic       ready;
  logic       tick_us;
  logic       tick_ms;
  logic [7:0] lock_loss_cnt;

  int checks   = 0;
  int failures = 0;

  int mRstEdges = 0;
  bit mArmed    = 1'b0;
  bit mSync1    = 1'b0;
  bit mSync2    = 1'b0;
  int mStreak   = 0;
  int mLoss     = 0;

  clk_rst_seq #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .US_DIV        (US_DIV),
    .MS_DIV        (MS_DIV)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .pll_lock      (pll_lock),
    .rst_out_n     (rst_out_n),
    .ready         (ready),
    .tick_us       (tick_us),
    .tick_ms       (tick_ms),
    .lock_loss_cnt (lock_loss_cnt)
  );

  // 100 MHz bench clock; only edge counts matter to the sequencer.
  always #5 sys_clk = ~sys_clk;

  // Shared comparison: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive pll_lock on a falling edge and hold it for the given number of
  // rising edges.
  task automatic applyStimulus(input bit lockVal, input int edges);
    @(negedge sys_clk);
    pll_lock = lockVal;
    repeat (edges) @(posedge sys_clk);
  endtask

  // Advance rising edges and settle 1 time unit past the last one.
  task automatic stepEdges(input int edges);
    repeat (edges) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Behavioural model. The internal reset lifts two edges after the button;
  // the next edge arms the lock path; the lock flag then reaches the
  // sequencer two edges late. The design is running once the synchronised
  // lock has been high for more than SETTLE_CYCLES consecutive edges, and a
  // drop while running is one counted loss.
  always @(posedge sys_clk or negedge sys_rst_n) begin : modelProc
    bit lockNow;
    if (!sys_rst_n) begin
      mRstEdges = 0;
      mArmed    = 1'b0;
      mSync1    = 1'b0;
      mSync2    = 1'b0;
      mStreak   = 0;
      mLoss     = 0;
    end else if (mRstEdges < 2) begin
      mRstEdges++;
    end else begin
      lockNow = mSync2;
      mSync2  = mSync1;
      mSync1  = pll_lock & mArmed;
      if (!mArmed) begin
        mArmed = 1'b1;
      end else if (lockNow) begin
        mStreak++;
      end else begin
        if (mStreak > SETTLE_CYCLES && mLoss < 255) begin
          mLoss++;
        end
        mStreak = 0;
      end
    end
  end

  // Every cycle, on the falling edge, the outputs must match the model.
  always @(negedge sys_clk) begin : compareProc
    bit running;
    int runCycle;
    running  = (mStreak > SETTLE_CYCLES);
    runCycle = mStreak - SETTLE_CYCLES;
    checkOutput("model_rst_out_n", int'(rst_out_n), int'(running));
    checkOutput("model_ready", int'(ready), int'(running));
    checkOutput("model_tick_us", int'(tick_us), int'(running && (runCycle % US_DIV == 0)));
    checkOutput("model_tick_ms", int'(tick_ms),
                int'(running && (runCycle % (US_DIV * MS_DIV) == 0)));
    checkOutput("model_lock_loss_cnt", int'(lock_loss_cnt), mLoss);
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int usCount;
    int usMisplaced;
    int msCount;
    int firstMs;
    int seenReady;
    int events;
    int hi;

    $display("[TB] start");

    // Reset held: everything at its reset value.
    stepEdges(3);
    checkOutput("reset_rst_out_n", int'(rst_out_n), 0);
    checkOutput("reset_ready", int'(ready), 0);
    checkOutput("reset_ticks", int'(tick_us) + int'(tick_ms), 0);
    checkOutput("reset_loss", int'(lock_loss_cnt), 0);

    // Power-up with lock already present: 2 + 1 + 2 + 1 + 16 = 22 edges.
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    stepEdges(21);
    checkOutput("powerup_edge21_rst_out_n", int'(rst_out_n), 0);
    checkOutput("powerup_edge21_ready", int'(ready), 0);
    stepEdges(1);
    checkOutput("powerup_edge22_rst_out_n", int'(rst_out_n), 1);
    checkOutput("powerup_edge22_ready", int'(ready), 1);

    // Ticks over the first 40 running cycles: tick_us on every 4th,
    // tick_ms on the 5th and 10th tick_us (cycles 20 and 40).
    usCount     = 0;
    usMisplaced = 0;
    msCount     = 0;
    firstMs     = 0;
    for (int c = 1; c <= 40; c++) begin
      if (tick_us) begin
        usCount++;
        if (c % 4 != 0) begin
          usMisplaced++;
        end
      end
      if (tick_ms) begin
        msCount++;
        if (firstMs == 0) begin
          firstMs = c;
        end
      end
      stepEdges(1);
    end
    checkOutput("ticks_us_count", usCount, 10);
    checkOutput("ticks_us_misplaced", usMisplaced, 0);
    checkOutput("ticks_ms_count", msCount, 2);
    checkOutput("ticks_ms_first_cycle", firstMs, 20);

    // Lock lost while running: lock_s falls after two edges and the
    // sequencer leaves S_RUN on the following edge.
    @(negedge sys_clk);
    pll_lock = 1'b0;
    stepEdges(2);
    checkOutput("lossrun_edge2_ready", int'(ready), 1);
    stepEdges(1);
    checkOutput("lossrun_edge3_ready", int'(ready), 0);
    checkOutput("lossrun_edge3_rst_out_n", int'(rst_out_n), 0);
    checkOutput("lossrun_edge3_tick_us", int'(tick_us), 0);
    checkOutput("lossrun_loss_cnt", int'(lock_loss_cnt), 1);

    // Relock, then glitch low for 3 cycles so lock_s drops at settle count 10.
    // The settle restarts; S_RUN comes 19 edges after the final relock.
    seenReady = 0;
    @(negedge sys_clk);
    pll_lock = 1'b1;
    for (int e = 0; e < 11; e++) begin
      stepEdges(1);
      seenReady += int'(ready);
    end
    @(negedge sys_clk);
    pll_lock = 1'b0;
    for (int e = 0; e < 3; e++) begin
      stepEdges(1);
      seenReady += int'(ready);
    end
    @(negedge sys_clk);
    pll_lock = 1'b1;
    for (int e = 0; e < 18; e++) begin
      stepEdges(1);
      seenReady += int'(ready);
    end
    checkOutput("glitch_no_early_ready", seenReady, 0);
    stepEdges(1);
    checkOutput("glitch_relock_ready", int'(ready), 1);
    checkOutput("glitch_loss_unchanged", int'(lock_loss_cnt), 1);
    stepEdges(3);
    checkOutput("rerun_first_tick_us", int'(tick_us), 1);

    // Randomised lock activity until 300 losses in S_RUN have occurred;
    // some high periods are too short to reach S_RUN at all.
    events = 1;
    while (events < 300) begin
      if ($urandom_range(0, 3) == 0) begin
        hi = $urandom_range(3, 15);
      end else begin
        hi = $urandom_range(19, 30);
        events++;
      end
      applyStimulus(1'b1, hi);
      applyStimulus(1'b0, $urandom_range(1, 4));
    end
    stepEdges(4);
    checkOutput("saturate_loss_cnt", int'(lock_loss_cnt), 255);
    checkOutput("saturate_ready", int'(ready), 0);

    // Asynchronous reset between edges while running.
    applyStimulus(1'b1, 25);
    #2;
    checkOutput("async_pre_ready", int'(ready), 1);
    #1;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_n", int'(rst_out_n), 0);
    checkOutput("async_ready", int'(ready), 0);
    checkOutput("async_ticks", int'(tick_us) + int'(tick_ms), 0);
    checkOutput("async_loss_cnt", int'(lock_loss_cnt), 0);

    // Recovery repeats the full 22-edge sequence.
    stepEdges(2);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    stepEdges(21);
    checkOutput("recover_edge21_ready", int'(ready), 0);
    stepEdges(1);
    checkOutput("recover_edge22_ready", int'(ready), 1);
    checkOutput("recover_edge22_rst_out_n", int'(rst_out_n), 1);
    stepEdges(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
